esp32_key_pio: RTL and testbench

ESP32_KEY_PIO -- requirements
Module: esp32_key_pio

---
 rtl/esp32_key_pio.sv | 95 +++++++++
 tb/tb_esp32_key_pio.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/esp32_key_pio.sv
// Debounced key PIO with edge capture, interrupt mask and an Avalon-MM slave.
// Each key is synchronized, debounced by a per-bit counter, then edge-captured.
module esp32_key_pio #(
  parameter int WIDTH    = 4,
  parameter int DB_COUNT = 50000,
  parameter int EDGE     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(DB_COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

  logic [WIDTH-1:0] sync1, sync2, stable, stable_next;
  logic [WIDTH-1:0] rise, fall, det;
  logic [WIDTH-1:0] edgecap, edgecap_next, irqmask, clr_mask, rd_mux;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic             wr_en, rd_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign rd_en        = chipselect &  write_n;
  assign unused_wdata = ^writedata;

  // Counter holds DB_COUNT-1 after that many mismatching edges; the next one commits.
  always_comb begin
    stable_next = stable;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) stable_next[i] = sync2[i];
        else                    cnt_next[i]    = cnt[i] + 1'b1;
      end
    end
  end

  assign rise = ~stable &  stable_next;
  assign fall =  stable & ~stable_next;

  always_comb begin
    det = '0;
    if (EDGE == 0)      det = rise;
    else if (EDGE == 1) det = fall;
    else                det = rise | fall;
  end

  // Clear first, then OR in new captures so a simultaneous capture wins.
  always_comb begin
    clr_mask = '0;
    if (wr_en && address == 2'd3) clr_mask = writedata[WIDTH-1:0];
    edgecap_next = (edgecap & ~clr_mask) | det;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = stable;
      2'd1:    rd_mux = sync2;
      2'd2:    rd_mux = irqmask;
      default: rd_mux = edgecap;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '1;
      sync2    <= '1;
      stable   <= '1;
      edgecap  <= '0;
      irqmask  <= '0;
      readdata <= '0;
      irq      <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1   <= in_port;
      sync2   <= sync1;
      stable  <= stable_next;
      edgecap <= edgecap_next;
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
      if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
      if (rd_en) readdata <= 32'(rd_mux);
      irq <= |(edgecap & irqmask);
    end
  end

endmodule

// File: tb/tb_esp32_key_pio.sv
// Directed bench for esp32_key_pio (WIDTH=4, DB_COUNT=4, EDGE=1).
// A read issued before edge N returns the register value held before edge N.
module tb_esp32_key_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  in;
    logic        cs;
    logic        wr_n;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  esp32_key_pio #(.WIDTH(4), .DB_COUNT(4), .EDGE(1)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    step();
    chipselect = 1'b0;
    check(name, readdata, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] in, input logic cs, input logic wr_n,
                              input logic [1:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rd, input logic exp_irq);
    vec_t v;
    v.in = in; v.cs = cs; v.wr_n = wr_n; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    return v;
  endfunction

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 4'hF;

    // Press: stable falls on edge 6, visible through DATA on edge 7
    for (int i = 1; i <= 6; i++) vecs.push_back(mk(4'hE, 1, 1, 2'd0, 0, 32'hF, 0));
    vecs.push_back(mk(4'hE, 1, 1, 2'd0, 0, 32'hE, 0));
    vecs.push_back(mk(4'hE, 1, 1, 2'd3, 0, 32'h1, 0));
    vecs.push_back(mk(4'hE, 1, 1, 2'd1, 0, 32'hE, 0));
    // Release (rising, not captured): stable rises on edge 15
    for (int i = 10; i <= 15; i++) vecs.push_back(mk(4'hF, 1, 1, 2'd0, 0, 32'hE, 0));
    vecs.push_back(mk(4'hF, 1, 1, 2'd0, 0, 32'hF, 0));
    vecs.push_back(mk(4'hF, 1, 1, 2'd3, 0, 32'h1, 0));
    vecs.push_back(mk(4'hF, 1, 0, 2'd3, 32'h1, 32'h1, 0));
    vecs.push_back(mk(4'hF, 1, 1, 2'd3, 0, 32'h0, 0));
    // Glitch: bit0 low for 3 cycles only
    for (int i = 0; i < 3; i++) vecs.push_back(mk(4'hE, 1, 1, 2'd0, 0, 32'hF, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(4'hF, 1, 1, 2'd0, 0, 32'hF, 0));
    vecs.push_back(mk(4'hF, 1, 1, 2'd3, 0, 32'h0, 0));

    step(); step();
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      in_port = vecs[i].in; chipselect = vecs[i].cs; write_n = vecs[i].wr_n;
      address = vecs[i].addr; writedata = vecs[i].wdata;
      step();
      check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;

    // IRQ and clear
    bus_write(2'd2, 32'h1);
    check("irq_masked_idle", {31'b0, irq}, 32'h0);
    in_port = 4'hE;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("irq_pre_%0d", k), {31'b0, irq}, 32'h0);
    end
    step();
    check("irq_after_capture", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h1);
    step();
    check("irq_after_clear", {31'b0, irq}, 32'h0);
    bus_write(2'd3, 32'h0);
    step();
    check("irq_after_zero_w1c", {31'b0, irq}, 32'h0);
    bus_read(2'd3, 32'h0, "edgecap_after_zero_w1c");
    in_port = 4'hF;
    repeat (8) step();

    // Capture/clear collision on bit1, then mask set with edgecap already pending
    in_port = 4'hD;
    repeat (5) step();
    bus_write(2'd3, 32'h2);
    bus_read(2'd3, 32'h2, "collision_capture_wins");
    check("irq_other_bit_masked", {31'b0, irq}, 32'h0);
    bus_write(2'd2, 32'h2);
    step();
    check("irq_mask_set_late", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h2);
    step();
    check("irq_clear_bit1", {31'b0, irq}, 32'h0);
    in_port = 4'hF;
    repeat (8) step();

    // Reset mid-debounce with bit2 held low
    in_port = 4'hB;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_readdata", readdata, 32'h0);
    check("midreset_irq", {31'b0, irq}, 32'h0);
    bus_read(2'd2, 32'h0, "midreset_irqmask");
    bus_read(2'd3, 32'h0, "midreset_edgecap");
    for (int k = 3; k <= 7; k++)
      bus_read(2'd0, (k == 7) ? 32'hB : 32'hF, $sformatf("midreset_data_r%0d", k));
    bus_read(2'd3, 32'h4, "midreset_fall_captured");
    check("midreset_irq_after", {31'b0, irq}, 32'h0);

    // Readback of masked IRQMASK width, ignored write to DATA, read hold
    bus_write(2'd2, 32'hFFFF_FFFA);
    bus_read(2'd2, 32'h0000_000A, "irqmask_readback");
    bus_write(2'd0, 32'h0);
    bus_read(2'd0, 32'hB, "data_write_ignored");
    step();
    check("readdata_hold", readdata, 32'hB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
